// File: rtl/keccak_digest_serializer_pkg.sv
// Shared definitions for the Keccak digest serializer.
// Holds the state/digest/word geometry, the FSM state encoding and a helper
// that picks one output word out of the captured digest.
package keccak_digest_serializer_pkg;

    localparam int STATE_W   = 1600;
    localparam int DIGEST_W  = 512;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = DIGEST_W / WORD_W;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Word 0 is the most significant word of the digest.
    function automatic logic [WORD_W-1:0] word_select(
        input logic [DIGEST_W-1:0] digest,
        input logic [IDX_W-1:0]    idx
    );
        logic [DIGEST_W-1:0] shifted;
        shifted = digest << (idx * WORD_W);
        return shifted[DIGEST_W-1 -: WORD_W];
    endfunction

endpackage

// File: rtl/keccak_digest_serializer.sv
// Keccak digest serializer.
// Watches the permutation state and its ready flag; once the permutation of
// the final absorbed block completes, captures the top DIGEST_W state bits
// and streams them out MSB-first as WORD_W words over valid/ready, then
// pulses digest_done.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   clear        synchronous abort back to IDLE (highest priority)
//   state_in     permutation state
//   state_ready  permutation-complete level flag
//   final_in     pulse: final padded block accepted by the permutation
//   dout         current digest word (registered)
//   dout_valid   dout holds a valid word
//   dout_ready   sink accepts the word
//   digest_done  one-cycle pulse after the last word transfers
//   busy         armed or sending
//   overrun      sticky: a new digest completed while still sending
module keccak_digest_serializer
    import keccak_digest_serializer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_ready,
    input  logic               final_in,
    output logic [WORD_W-1:0]  dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               digest_done,
    output logic               busy,
    output logic               overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    ser_state_e          state_q, state_d;
    logic                armed_q, armed_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sr_dly_q, sr_dly_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [WORD_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic rise;
    logic xfer;

    // Edge, not level: state_ready is still high from the previous
    // permutation in the cycle final_in arrives, so the level would
    // capture a stale state.
    assign rise = state_ready & ~sr_dly_q;
    assign xfer = dout_valid_q & dout_ready;

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        idx_d        = idx_q;
        sr_dly_d     = state_ready;
        digest_d     = digest_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;

        if (clear) begin
            state_d      = IDLE;
            armed_d      = 1'b0;
            idx_d        = '0;
            dout_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // final_in in the same cycle as rise counts as armed.
                    if (rise && (armed_q || final_in)) begin
                        digest_d     = state_in[STATE_W-1 -: DIGEST_W];
                        dout_d       = state_in[STATE_W-1 -: WORD_W];
                        dout_valid_d = 1'b1;
                        idx_d        = '0;
                        armed_d      = 1'b0;
                        state_d      = SEND;
                    end else if (final_in) begin
                        armed_d = 1'b1;
                    end
                end
                SEND: begin
                    // A digest finishing mid-stream is dropped; armed stays
                    // set so a later permutation can still be captured.
                    if (rise && armed_q) begin
                        overrun_d = 1'b1;
                    end
                    if (final_in) begin
                        armed_d = 1'b1;
                    end
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            dout_valid_d = 1'b0;
                            done_d       = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            idx_d  = idx_q + IDX_W'(1);
                            dout_d = word_select(digest_q, idx_q + IDX_W'(1));
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            idx_q        <= '0;
            sr_dly_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            idx_q        <= idx_d;
            sr_dly_q     <= sr_dly_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Digest storage is pure data and is only read while sending.
    always_ff @(posedge clk) begin
        digest_q <= digest_d;
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign digest_done = done_q;
    assign overrun     = overrun_q;
    assign busy        = armed_q | (state_q == SEND);

endmodule

// File: tb/tb_keccak_digest_serializer.sv
// Testbench for keccak_digest_serializer: directed scenarios plus a
// randomized phase, all checked against a transaction-level reference model
// that keeps the pending digest words in a queue.
module tb_keccak_digest_serializer;
    import keccak_digest_serializer_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic [STATE_W-1:0] state_in;
    logic               state_ready;
    logic               final_in;
    logic [WORD_W-1:0]  dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               digest_done;
    logic               busy;
    logic               overrun;

    keccak_digest_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .state_in    (state_in),
        .state_ready (state_ready),
        .final_in    (final_in),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .digest_done (digest_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_xfer = 0;
    int n_done = 0;

    logic [STATE_W-1:0] st;

    // Reference model state
    bit          m_send, m_armed, m_ovr, m_done, m_prev;
    logic [31:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_send = 0; m_armed = 0; m_ovr = 0; m_done = 0; m_prev = 0;
        m_q.delete();
    endtask

    // One clock of the reference model, evaluated on the inputs about to be sampled.
    task automatic model_clk();
        bit rise, was_send, old_armed;
        logic [DIGEST_W-1:0] dig, sh;
        rise      = state_ready & ~m_prev;
        was_send  = m_send;
        old_armed = m_armed;
        m_prev    = state_ready;
        if (clear) begin
            m_send = 0; m_armed = 0; m_ovr = 0; m_done = 0;
            m_q.delete();
        end else begin
            m_done = 0;
            if (was_send) begin
                if (rise && old_armed) m_ovr = 1;
                if (final_in) m_armed = 1;
                if (dout_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_send = 0;
                        m_done = 1;
                    end
                end
            end else if (rise && (old_armed || final_in)) begin
                dig = state_in[STATE_W-1 -: DIGEST_W];
                m_q.delete();
                for (int k = 0; k < NUM_WORDS; k++) begin
                    sh = dig << (32 * k);
                    m_q.push_back(sh[DIGEST_W-1 -: 32]);
                end
                m_send  = 1;
                m_armed = 0;
            end else if (final_in) begin
                m_armed = 1;
            end
        end
    endtask

    task automatic rand_st();
        for (int i = 0; i < 50; i++) st = {st[STATE_W-33:0], $urandom()};
    endtask

    // Drive one cycle of inputs, step the model, then compare after the edge.
    task automatic cyc(input logic fin, input logic srdy, input logic drdy, input logic clr);
        final_in    = fin;
        state_ready = srdy;
        dout_ready  = drdy;
        clear       = clr;
        state_in    = st;
        if (dout_valid && drdy && !clr) n_xfer++;
        model_clk();
        @(posedge clk);
        #1;
        if (digest_done) n_done++;
        check("dout_valid", dout_valid, m_send);
        if (m_send) check("dout", dout, m_q[0]);
        check("digest_done", digest_done, m_done);
        check("busy", busy, m_armed | m_send);
        check("overrun", overrun, m_ovr);
    endtask

    initial begin
        logic [DIGEST_W-1:0] dig;
        logic [31:0] w0, expw;

        reset = 1; clear = 0; final_in = 0; state_ready = 0; dout_ready = 0;
        st = '0; state_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_done", digest_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset = 0;

        // Basic capture: byte k of the digest equals k
        dig = '0;
        for (int k = 0; k < 64; k++) dig = {dig[DIGEST_W-9:0], 8'(k)};
        rand_st();
        st[STATE_W-1 -: DIGEST_W] = dig;
        cyc(1, 0, 1, 0);
        repeat (23) cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        for (int k = 0; k < NUM_WORDS; k++) begin
            expw = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            check("basic_word", dout, expw);
            cyc(0, 1, 1, 0);
        end
        check("basic_done", digest_done, 1);
        cyc(0, 1, 1, 0);

        // Intermediate permutations are ignored, third one is captured
        repeat (3) cyc(0, 0, 1, 0);
        rand_st(); cyc(0, 1, 1, 0); repeat (2) cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 0);
        rand_st(); cyc(0, 1, 1, 0);
        check("intm_busy", busy, 0);
        cyc(0, 0, 1, 0);
        rand_st();
        cyc(1, 0, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        check("intm_word0", dout, st[STATE_W-1 -: 32]);
        repeat (20) cyc(0, 1, 1, 0);

        // Back-pressure with ready pattern 1,0,0,...
        cyc(0, 0, 0, 0);
        rand_st();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        n_xfer = 0; n_done = 0;
        for (int i = 0; i < 60; i++) cyc(0, 1, (i % 3) == 0, 0);
        check("bp_xfers", n_xfer, 16);
        check("bp_done_count", n_done, 1);

        // final_in in the same cycle as the rise
        cyc(0, 0, 1, 0);
        rand_st();
        cyc(1, 1, 1, 0);
        check("arm_same_valid", dout_valid, 1);
        repeat (20) cyc(0, 1, 1, 0);
        check("arm_same_busy", busy, 0);
        // final_in while state_ready is already high: waits for next rise
        cyc(1, 1, 1, 0);
        repeat (5) cyc(0, 1, 1, 0);
        check("arm_level_valid", dout_valid, 0);
        check("arm_level_busy", busy, 1);
        cyc(0, 0, 1, 0);
        rand_st();
        cyc(0, 1, 1, 0);
        check("arm_level_capture", dout_valid, 1);
        repeat (20) cyc(0, 1, 1, 0);

        // Overrun while stalled, then clear
        cyc(0, 0, 0, 0);
        rand_st();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        w0 = st[STATE_W-1 -: 32];
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        rand_st();
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("ovr_flag", overrun, 1);
        check("ovr_word", dout, w0);
        cyc(0, 1, 0, 1);
        check("clr_overrun", overrun, 0);
        check("clr_valid", dout_valid, 0);
        check("clr_busy", busy, 0);

        // Asynchronous reset at word 7
        cyc(0, 0, 1, 0);
        rand_st();
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        repeat (7) cyc(0, 1, 1, 0);
        check("pre_rst_valid", dout_valid, 1);
        #2 reset = 1;
        #1;
        check("async_rst_valid", dout_valid, 0);
        check("async_rst_dout", dout, 0);
        check("async_rst_busy", busy, 0);
        model_reset();
        state_ready = 0; dout_ready = 0;
        @(posedge clk);
        #1 reset = 0;
        cyc(0, 0, 1, 0);
        rand_st();
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        check("post_rst_word0", dout, st[STATE_W-1 -: 32]);
        n_done = 0;
        repeat (17) cyc(0, 1, 1, 0);
        check("post_rst_done", n_done, 1);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic sr;
            sr = state_ready;
            if ($urandom_range(0, 5) == 0) sr = ~sr;
            if ($urandom_range(0, 3) == 0) rand_st();
            cyc($urandom_range(0, 11) == 0, sr, $urandom_range(0, 2) != 0,
                $urandom_range(0, 79) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keccak_digest_serializer.md
Name: keccak_digest_serializer

Overview:
- Downstream consumer of the permutation stage. Watches the 1600-bit state and its ready flag.
- When the permutation of the final absorbed block completes, it captures the 512-bit digest, the top 512 state bits.
- Streams the digest out as 32-bit words over a valid/ready handshake, then pulses done. It sits between the permutation core and the core's external output port.

Parameters:
- STATE_W, 1600, width of permutation state.
- DIGEST_W, 512, digest bits taken from the state MSB end.
- WORD_W, 32, output word width; DIGEST_W/WORD_W = 16 words.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort; returns the block to IDLE.
- state_in  in  STATE_W  permutation state.
- state_ready  in  1  permutation-complete level flag. It drops on accept and rises after the last round.
- final_in  in  1  one-cycle pulse: the final padded block was accepted by the permutation.
- dout  out  WORD_W  digest word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  sink accepts the word.
- digest_done  out  1  one-cycle pulse after the last word is transferred.
- busy  out  1  armed or sending.
- overrun  out  1  sticky error flag.

Behaviour:
- Only one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: dout=0, dout_valid=0, digest_done=0, busy=0, overrun=0, armed=0, idx=0, state_ready_d=0, state=IDLE.
- rise = state_ready & ~state_ready_d, where state_ready_d is a register.
  - Capture uses the edge, not the level, because state_ready is still high on the cycle final_in coincides with accept. Level capture would take stale state.
- armed: set by final_in; cleared on capture, clear or reset. final_in while already armed has no further effect.
- FSM IDLE:
  - On rise & armed (or rise & final_in in the same cycle): latch digest_reg = state_in[STATE_W-1 -: DIGEST_W], set idx=0, clear armed, go to SEND.
  - rise without armed is ignored; it is an intermediate absorb permutation.
- FSM SEND:
  - dout_valid=1 and dout = digest_reg word idx. Word 0 = digest_reg[511:480], word 15 = digest_reg[31:0], MSB-first.
  - dout is registered and updates the cycle after a transfer. A transfer happens when dout_valid & dout_ready.
  - On a transfer with idx<15: idx++.
  - On a transfer with idx==15: dout_valid=0, digest_done=1 for one cycle, go to IDLE.
  - The digest is stable while dout_valid is high and dout_ready is low. dout_ready may be held high for a back-to-back transfer every cycle.
- Minimum latency: rise at cycle N gives dout_valid at N+1. Sixteen transfers with dout_ready held high finish at N+16, and digest_done is asserted at N+17.
- busy = armed | (state==SEND).
- overrun:
  - Sets when rise & armed occurs while in SEND. The new digest is dropped and armed is retained.
  - Sticky until reset or clear.
- final_in during SEND: sets armed. The next rise after returning to IDLE captures.
- clear: any state goes to IDLE, with dout_valid=0, armed=0, overrun=0 and no digest_done. clear has priority over every other event in the same cycle.
- Async reset mid-SEND: all outputs return to reset values immediately, without waiting for a clock edge.
- The block never back-pressures the permutation stage; it has no ack upstream.

Decomposition:
- Shared package: STATE_W, DIGEST_W, WORD_W, derived NUM_WORDS=16, IDX_W=4, and the FSM state encoding IDLE=0, SEND=1.
- No sub-module; one module of roughly 150 RTL lines.
- An optional generic word-mux helper (word_select) is permitted but not required.

Test Plan:
- Basic capture:
  - Stimulus: final_in pulse; state_in[1599:1088] = 0x000102...3F (byte k = k); state_ready rises 24 cycles later; dout_ready=1.
  - Required response: 16 words 0x00010203, 0x04050607 … 0x3C3D3E3F on consecutive cycles, digest_done one cycle after the last transfer.
- Intermediate permutation ignored:
  - Stimulus: two rises without final_in.
  - Required response: dout_valid stays 0 and busy stays 0.
  - Then final_in followed by a rise: capture occurs with the third state value.
- Back-pressure:
  - Stimulus: dout_ready toggles 1,0,0,1… during SEND.
  - Required response: dout stays stable while stalled, no word is skipped or duplicated, exactly 16 transfers occur, and digest_done fires once.
- Same-cycle arm:
  - Stimulus: final_in asserted in the same cycle as rise.
  - Required response: capture happens and armed ends at 0.
  - Stimulus: final_in while state_ready is already high and no rise occurs.
  - Required response: no capture until the next rise.
- Overrun and clear:
  - Stimulus: rise & armed while in SEND with dout_ready=0.
  - Required response: overrun=1, the current digest words are unchanged.
  - Stimulus: clear.
  - Required response: overrun=0, dout_valid=0, state IDLE.
- Reset mid-stream:
  - Stimulus: assert reset asynchronously at word 7.
  - Required response: dout_valid=0, dout=0 and busy=0 before the next clk edge.
  - After release, a fresh final_in and rise produce a full 16-word stream starting from word 0.
